// File: rtl/alu_secuencial.sv
`default_nettype none
// alu_secuencial: clocked ALU with registered result/flags; MUL, DIV and MOD
// iterate for N cycles behind a start/busy/done handshake.
module alu_secuencial #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic [3:0]     sel,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] result,
   output logic           negativo_bandera,
   output logic           zr_bandera,
   output logic           cry_bandera,
   output logic           of_bandera,
   output logic           div_cero
);

   localparam logic [3:0] OP_MUL = 4'b0000;
   localparam logic [3:0] OP_MOD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SUB = 4'b0101;
   localparam logic [3:0] OP_DIV = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b0111;
   localparam logic [3:0] OP_SHR = 4'b1000;
   localparam logic [3:0] OP_ADD = 4'b1001;
   localparam int         CW     = $clog2(N) + 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [2*N-1:0]   prod_q, prod_d;
   logic [2*N-1:0]   mcand_q, mcand_d;
   logic [N-1:0]     mplier_q, mplier_d;
   logic [N-1:0]     rem_q, rem_d;
   logic [N-1:0]     quo_q, quo_d;
   logic [N-1:0]     divisor_q, divisor_d;
   logic [2*N-1:0]   result_q, result_d;
   logic             neg_q, neg_d;
   logic             zr_q, zr_d;
   logic             cry_q, cry_d;
   logic             of_q, of_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;

   // Single-cycle datapath, evaluated straight from the inputs at acceptance
   logic [N:0]       sum;
   logic [N-1:0]     diff;
   logic [2*N-1:0]   sc_res;
   logic             sc_neg, sc_cry, sc_of, sc_dz, shr_cry;

   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = A - B;

   always_comb begin
      sc_res  = '0;
      sc_cry  = 1'b0;
      sc_of   = 1'b0;
      sc_dz   = 1'b0;
      shr_cry = 1'b0;
      for (int i = 1; i <= N; i++) begin
         if (B == N'(i)) shr_cry = A[i-1];
      end
      case (sel)
         OP_AND: sc_res = {{N{1'b0}}, A & B};
         OP_OR:  sc_res = {{N{1'b0}}, A | B};
         OP_XOR: sc_res = {{N{1'b0}}, A ^ B};
         OP_SUB: begin
            sc_res = {{N{1'b0}}, diff};
            sc_cry = (A < B);
            sc_of  = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
         end
         OP_ADD: begin
            sc_res = {{(N-1){1'b0}}, sum};
            sc_cry = sum[N];
            sc_of  = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
         end
         OP_SHL: sc_res = {{N{1'b0}}, A} << B;
         OP_SHR: begin
            sc_res = {{N{1'b0}}, A >> B};
            sc_cry = shr_cry;
         end
         // Only reached with B == 0; nonzero divisors go through CALC
         OP_DIV: begin
            sc_res = {{N{1'b0}}, {N{1'b1}}};
            sc_dz  = 1'b1;
         end
         OP_MOD: begin
            sc_res = {{N{1'b0}}, A};
            sc_dz  = 1'b1;
         end
         default: sc_res = '0;
      endcase
      sc_neg = (sel == OP_SHL) ? sc_res[2*N-1] : sc_res[N-1];
   end

   // One shift-add and one restoring-divide step per CALC cycle
   logic [2*N-1:0]   prod_nx;
   logic [N:0]       rem_shift, rem_sub;
   logic             rem_ge;
   logic [N-1:0]     rem_nx, quo_nx;

   always_comb begin
      prod_nx   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
      rem_shift = {rem_q, quo_q[N-1]};
      rem_ge    = (rem_shift >= {1'b0, divisor_q});
      rem_sub   = rem_shift - {1'b0, divisor_q};
      rem_nx    = rem_ge ? N'(rem_sub) : N'(rem_shift);
      quo_nx    = {quo_q[N-2:0], rem_ge};
   end

   logic start_multi;
   assign start_multi = (sel == OP_MUL) ||
                        (((sel == OP_DIV) || (sel == OP_MOD)) && (B != '0));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      prod_d    = prod_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      result_d  = result_q;
      neg_d     = neg_q;
      zr_d      = zr_q;
      cry_d     = cry_q;
      of_d      = of_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (start_multi) begin
                  state_d   = CALC;
                  cnt_d     = '0;
                  op_d      = sel;
                  prod_d    = '0;
                  mcand_d   = {{N{1'b0}}, A};
                  mplier_d  = B;
                  rem_d     = '0;
                  quo_d     = A;
                  divisor_d = B;
               end else begin
                  result_d = sc_res;
                  neg_d    = sc_neg;
                  zr_d     = (sc_res == '0);
                  cry_d    = sc_cry;
                  of_d     = sc_of;
                  dz_d     = sc_dz;
                  done_d   = 1'b1;
               end
            end
         end
         CALC: begin
            cnt_d    = cnt_q + CW'(1);
            prod_d   = prod_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            rem_d    = rem_nx;
            quo_d    = quo_nx;
            if (cnt_q == CW'(N - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               cry_d   = 1'b0;
               of_d    = 1'b0;
               dz_d    = 1'b0;
               if (op_q == OP_MUL) begin
                  result_d = prod_nx;
                  neg_d    = prod_nx[2*N-1];
                  zr_d     = (prod_nx == '0);
               end else if (op_q == OP_DIV) begin
                  result_d = {{N{1'b0}}, quo_nx};
                  neg_d    = quo_nx[N-1];
                  zr_d     = (quo_nx == '0);
               end else begin
                  result_d = {{N{1'b0}}, rem_nx};
                  neg_d    = rem_nx[N-1];
                  zr_d     = (rem_nx == '0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         prod_q    <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         result_q  <= '0;
         neg_q     <= 1'b0;
         zr_q      <= 1'b0;
         cry_q     <= 1'b0;
         of_q      <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         prod_q    <= prod_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         result_q  <= result_d;
         neg_q     <= neg_d;
         zr_q      <= zr_d;
         cry_q     <= cry_d;
         of_q      <= of_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
      end
   end

   assign busy             = (state_q == CALC);
   assign done             = done_q;
   assign result           = result_q;
   assign negativo_bandera = neg_q;
   assign zr_bandera       = zr_q;
   assign cry_bandera      = cry_q;
   assign of_bandera       = of_q;
   assign div_cero         = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_secuencial.sv
`default_nettype none
// tb_alu_secuencial: directed-vector bench for alu_secuencial with N=4.
// Observed vector layout: {busy, done, result[7:0], neg, zr, cry, of, div_cero}.
module tb_alu_secuencial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic [3:0] sel = '0;
   logic       busy, done;
   logic [7:0] result;
   logic       neg, zr, cry, of, dz;
   logic [14:0] obs;

   int checks = 0;
   int errors = 0;
   int lat, bcnt;

   always #5 clk = ~clk;

   alu_secuencial #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sel(sel),
      .busy(busy), .done(done), .result(result),
      .negativo_bandera(neg), .zr_bandera(zr), .cry_bandera(cry),
      .of_bandera(of), .div_cero(dz)
   );

   assign obs = {busy, done, result, neg, zr, cry, of, dz};

   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      @(negedge clk);
      A = a; B = b; sel = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done; lat = edges after acceptance, bcnt = busy samples
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      issue(a, b, s);
      lat = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (obs !== 15'b0) begin
         errors++;
         $display("FAIL reset_state got %h exp %h", obs, 15'b0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      run_op(4'b0101, 4'b1000, 4'b1001);
      checks++;
      if (obs !== {2'b01, 8'h0D, 5'b10000} || lat != 0) begin
         errors++;
         $display("FAIL add_basic got %h lat %0d exp %h lat 0", obs, lat, {2'b01, 8'h0D, 5'b10000});
      end
      run_op(4'b0111, 4'b0001, 4'b1001);
      checks++;
      if (obs !== {2'b01, 8'h08, 5'b10010}) begin
         errors++;
         $display("FAIL add_overflow got %h exp %h", obs, {2'b01, 8'h08, 5'b10010});
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {2'b00, 8'h08, 5'b10010}) begin
         errors++;
         $display("FAIL add_hold got %h exp %h", obs, {2'b00, 8'h08, 5'b10010});
      end
      run_op(4'b1111, 4'b0001, 4'b1001);
      checks++;
      if (obs !== {2'b01, 8'h10, 5'b00100}) begin
         errors++;
         $display("FAIL add_carry got %h exp %h", obs, {2'b01, 8'h10, 5'b00100});
      end
   endtask

   task automatic test_mul();
      run_op(4'b1010, 4'b0111, 4'b0000);
      checks++;
      if (obs !== {2'b01, 8'h46, 5'b00000} || lat != 4 || bcnt != 4) begin
         errors++;
         $display("FAIL mul_basic got %h lat %0d busy %0d exp %h lat 4 busy 4",
                  obs, lat, bcnt, {2'b01, 8'h46, 5'b00000});
      end
   endtask

   task automatic test_div();
      run_op(4'b1100, 4'b0100, 4'b0110);
      checks++;
      if (obs !== {2'b01, 8'h03, 5'b00000} || lat != 4 || bcnt != 4) begin
         errors++;
         $display("FAIL div_basic got %h lat %0d busy %0d exp %h lat 4 busy 4",
                  obs, lat, bcnt, {2'b01, 8'h03, 5'b00000});
      end
      run_op(4'b1010, 4'b0111, 4'b0001);
      checks++;
      if (obs !== {2'b01, 8'h03, 5'b00000} || lat != 4) begin
         errors++;
         $display("FAIL mod_basic got %h lat %0d exp %h lat 4", obs, lat, {2'b01, 8'h03, 5'b00000});
      end
      run_op(4'b1010, 4'b0000, 4'b0110);
      checks++;
      if (obs !== {2'b01, 8'h0F, 5'b10001} || lat != 0 || bcnt != 0) begin
         errors++;
         $display("FAIL div_zero got %h lat %0d busy %0d exp %h lat 0 busy 0",
                  obs, lat, bcnt, {2'b01, 8'h0F, 5'b10001});
      end
   endtask

   task automatic test_sub();
      run_op(4'b0101, 4'b0101, 4'b0101);
      checks++;
      if (obs !== {2'b01, 8'h00, 5'b01000}) begin
         errors++;
         $display("FAIL sub_zero_clears_dz got %h exp %h", obs, {2'b01, 8'h00, 5'b01000});
      end
      run_op(4'b1000, 4'b0001, 4'b0101);
      checks++;
      if (obs !== {2'b01, 8'h07, 5'b00010}) begin
         errors++;
         $display("FAIL sub_overflow got %h exp %h", obs, {2'b01, 8'h07, 5'b00010});
      end
      run_op(4'b0011, 4'b0101, 4'b0101);
      checks++;
      if (obs !== {2'b01, 8'h0E, 5'b10100}) begin
         errors++;
         $display("FAIL sub_borrow got %h exp %h", obs, {2'b01, 8'h0E, 5'b10100});
      end
      run_op(4'b0011, 4'b0101, 4'b1111);
      checks++;
      if (obs !== {2'b01, 8'h00, 5'b01000}) begin
         errors++;
         $display("FAIL undefined_op got %h exp %h", obs, {2'b01, 8'h00, 5'b01000});
      end
   endtask

   task automatic test_logic();
      logic [3:0] ops [3] = '{4'b0010, 4'b0011, 4'b0100};
      logic [7:0] exp_r [3] = '{8'h08, 8'h0E, 8'h06};
      logic [4:0] exp_f [3] = '{5'b10000, 5'b10000, 5'b00000};
      for (int i = 0; i < 3; i++) begin
         run_op(4'b1100, 4'b1010, ops[i]);
         checks++;
         if (obs !== {2'b01, exp_r[i], exp_f[i]}) begin
            errors++;
            $display("FAIL logic_op%0d got %h exp %h", i, obs, {2'b01, exp_r[i], exp_f[i]});
         end
      end
   endtask

   task automatic test_shift();
      logic [3:0] va [7] = '{4'b1010, 4'b1100, 4'b1011, 4'b1100, 4'b1001, 4'b1111, 4'b1111};
      logic [3:0] vb [7] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101};
      logic [3:0] vs [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0111, 4'b0111, 4'b0111, 4'b1000};
      logic [7:0] er [7] = '{8'h05, 8'h03, 8'h05, 8'h30, 8'h90, 8'h00, 8'h00};
      logic [4:0] ef [7] = '{5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b10000, 5'b01000, 5'b01000};
      for (int i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], vs[i]);
         checks++;
         if (obs !== {2'b01, er[i], ef[i]}) begin
            errors++;
            $display("FAIL shift_vec%0d got %h exp %h", i, obs, {2'b01, er[i], ef[i]});
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      A = 4'b0001; B = 4'b0010; sel = 4'b1001; start = 1'b1;
      @(posedge clk);
      #1;
      A = 4'b1111; B = 4'b0101; sel = 4'b0100;
      checks++;
      if (obs !== {2'b01, 8'h03, 5'b00000}) begin
         errors++;
         $display("FAIL b2b_first got %h exp %h", obs, {2'b01, 8'h03, 5'b00000});
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (obs !== {2'b01, 8'h0A, 5'b10000}) begin
         errors++;
         $display("FAIL b2b_second got %h exp %h", obs, {2'b01, 8'h0A, 5'b10000});
      end
   endtask

   task automatic test_ignore_busy();
      issue(4'b1111, 4'b1111, 4'b0000);
      lat = 0;
      @(negedge clk);
      @(negedge clk);
      A = 4'b0001; B = 4'b0001; sel = 4'b1001; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 2;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (obs !== {2'b01, 8'hE1, 5'b10000} || lat != 4) begin
         errors++;
         $display("FAIL mul_ignore_start got %h lat %0d exp %h lat 4", obs, lat, {2'b01, 8'hE1, 5'b10000});
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {2'b00, 8'hE1, 5'b10000}) begin
         errors++;
         $display("FAIL no_queued_start got %h exp %h", obs, {2'b00, 8'hE1, 5'b10000});
      end
   endtask

   task automatic test_reset_midop();
      int seen_done = 0;
      issue(4'b1111, 4'b1111, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 15'b0) begin
         errors++;
         $display("FAIL reset_async got %h exp %h", obs, 15'b0);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done) seen_done++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL reset_no_done got %0d exp 0", seen_done);
      end
      run_op(4'b0010, 4'b0011, 4'b1001);
      checks++;
      if (obs !== {2'b01, 8'h05, 5'b00000} || lat != 0) begin
         errors++;
         $display("FAIL after_reset_add got %h lat %0d exp %h lat 0", obs, lat, {2'b01, 8'h05, 5'b00000});
      end
      run_op(4'b0011, 4'b0011, 4'b0000);
      checks++;
      if (obs !== {2'b01, 8'h09, 5'b00000} || lat != 4) begin
         errors++;
         $display("FAIL after_reset_mul got %h lat %0d exp %h lat 4", obs, lat, {2'b01, 8'h09, 5'b00000});
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_div();
      test_sub();
      test_logic();
      test_shift();
      test_back_to_back();
      test_ignore_busy();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
Parametrised, clocked successor to the lab combinational ALU. It keeps the same 4-bit opcode map and flag set, and adds SUB and SHL. MUL, DIV and MOD run as iterative N-cycle operations (shift-add multiply, restoring divide) behind a start/busy/done handshake. Results and flags are registered and held, so the block can sit behind a register file or controller FSM in later labs.

Parameters:
N, 4, operand width in bits (N >= 2); result is 2N bits.

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
A  input  N  operand A (unsigned unless noted)
B  input  N  operand B / shift amount
sel  input  4  opcode
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: result and flags updated
result  output  2N  registered result
negativo_bandera  output  1  sign of result at op width W
zr_bandera  output  1  result == 0 (all 2N bits)
cry_bandera  output  1  carry / borrow / shifted-out bit
of_bandera  output  1  signed overflow
div_cero  output  1  DIV/MOD attempted with B=0

Behaviour:
- Reset (async, rst_n=0): all outputs 0 immediately; FSM to IDLE; iteration counter cleared; any in-flight op abandoned, no done afterwards.
- FSM states: IDLE, CALC. busy=1 exactly when state is CALC.
- Acceptance: start=1 at a rising edge while IDLE latches A, B and sel internally. Input changes after acceptance have no effect. start while busy=1 is ignored and not queued.
- Single-cycle ops, and DIV/MOD with B=0: result, flags and div_cero are written at the accepting edge. done=1 for the following cycle. State stays IDLE, so back-to-back starts are legal every cycle.
- MUL, and DIV/MOD with B!=0: the accepting edge enters CALC with counter=0. One iteration runs per edge. At the Nth edge after acceptance, result and flags are written, done=1, and state returns to IDLE. busy is high for exactly N cycles and drops in the same cycle done rises. start may be accepted in that done cycle.
- Opcodes (W = flag width; W=2N for MUL and SHL, N otherwise):
  - 0000 MUL: result = A*B, unsigned.
  - 0001 MOD: result = A mod B, zero-extended.
  - 0010 AND, 0011 OR, 0100 XOR: bitwise, zero-extended.
  - 0101 SUB: result[N-1:0] = A-B mod 2^N, upper bits 0. cry = borrow (A<B). of = A[N-1]!=B[N-1] and diff[N-1]!=A[N-1].
  - 0110 DIV: result = floor(A/B), zero-extended.
  - 0111 SHL: result = A << B, zero-extended to 2N. Result is 0 if B >= 2N. cry = 0.
  - 1000 SHR: result = A >> B, logical. Result is 0 if B >= N. cry = A[B-1] when 1 <= B <= N, else 0.
  - 1001 ADD: result[N:0] = A+B, upper bits 0. cry = result[N]. of = A[N-1]==B[N-1] and sum[N-1]!=A[N-1].
  - 1010-1111: result = 0, latency 1, zr=1, all other flags 0.
- Flags:
  - negativo_bandera = result[W-1].
  - cry_bandera and of_bandera are 0 for any op not listed above as setting them.
- Divide by zero: DIV gives result = {N'b0, N'b1...1}; MOD gives result = A. div_cero=1, latency 1, no CALC.
- div_cero is cleared by the next completed operation that is not a divide by zero.
- Outputs hold their values between done pulses.

Test Plan:
- ADD, N=4, A=0101 B=1000 -> done one cycle after start; result=00001101, neg=1, zr=0, cry=0, of=0. Then ADD A=0111 B=0001 -> result=00001000, of=1, neg=1.
- MUL A=1010 B=0111 -> busy high exactly 4 cycles; done in the cycle busy falls; result=01000110 (70), neg=0, zr=0.
- DIV A=1100 B=0100 -> result=00000011 after 4 cycles. MOD A=1010 B=0111 -> result=00000011. DIV A=1010 B=0000 -> result=00001111 with latency 1, div_cero=1, busy never high.
- SUB A=0011 B=0101 -> result=00001110, cry=1, neg=1, of=0. SUB A=0101 B=0101 -> result=0, zr=1, div_cero cleared.
- SHR A=1010 B=0001 -> result=00000101, cry=0. SHR A=1100 B=0010 -> result=00000011, cry=0. SHL A=1100 B=0010 -> result=00110000. SHR with B=0101 -> result=0, zr=1.
- Start MUL A=1111 B=1111, pulse start with ADD operands in cycle 2 -> ignored; result=11100001 after 4 cycles. Repeat and assert rst_n=0 in cycle 2 -> all outputs 0 at once, no done; next start executes normally.
